// File: rtl/temporal_conv_mac_if.sv
// Stream and coefficient-bus bundle for temporal_conv_mac.
// The master side feeds windows, writes coefficients and consumes results. The slave side is the MAC engine.
interface temporal_conv_mac_if #(
    parameter int DATA_W      = 16,
    parameter int COEF_W      = 16,
    parameter int WINDOW_SIZE = 32,
    parameter int NUM_FILTERS = 4,
    parameter int OUT_W       = 16
);
    localparam int DEPTH  = NUM_FILTERS * WINDOW_SIZE;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    logic                                window_valid;
    logic [WINDOW_SIZE-1:0][DATA_W-1:0]  window;
    logic                                busy;
    logic                                coef_we;
    logic [ADDR_W-1:0]                   coef_addr;
    logic [COEF_W-1:0]                   coef_data;
    logic                                coef_err;
    logic                                out_valid;
    logic                                out_ready;
    logic [FILT_W-1:0]                   out_filter;
    logic [OUT_W-1:0]                    out_data;
    logic                                overrun;
    logic [15:0]                         drop_count;

    modport master (
        output window_valid, window, coef_we, coef_addr, coef_data, out_ready,
        input  busy, coef_err, out_valid, out_filter, out_data, overrun, drop_count
    );

    modport slave (
        input  window_valid, window, coef_we, coef_addr, coef_data, out_ready,
        output busy, coef_err, out_valid, out_filter, out_data, overrun, drop_count
    );
endinterface

// File: rtl/temporal_conv_mac.sv
// Single-multiplier temporal convolution MAC: one dot product per filter per window, scaled and saturated.
// Define TCONV_ROUND_EN for round-half-up before the output shift. Otherwise the output is floored.
module temporal_conv_mac #(
    parameter int DATA_W      = 16,
    parameter int COEF_W      = 16,
    parameter int WINDOW_SIZE = 32,
    parameter int NUM_FILTERS = 4,
    parameter int ACC_W       = 40,
    parameter int FRAC_SHIFT  = 14,
    parameter int OUT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    temporal_conv_mac_if.slave bus
);
    localparam int DEPTH  = NUM_FILTERS * WINDOW_SIZE;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TAP_W  = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                             state;
    logic [WINDOW_SIZE-1:0][DATA_W-1:0] snap;
    logic [COEF_W-1:0]                  coef [DEPTH];
    logic [TAP_W-1:0]                   tap;
    logic [FILT_W-1:0]                  filter;
    logic signed [ACC_W-1:0]            acc;

    logic                      last_filter, hs, accept, drop, addr_ok;
    logic [ADDR_W-1:0]         rd_addr;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W:0]     rnd, shifted;
    logic [OUT_W-1:0]          sat_val;

    assign last_filter = (filter == FILT_W'(NUM_FILTERS - 1));
    assign hs          = (state == OUT) && bus.out_ready;
    // A new window may start in the very cycle the last result is handed off.
    assign bus.busy    = !((state == IDLE) || (hs && last_filter));
    assign accept      = bus.window_valid && !bus.busy;
    assign drop        = bus.window_valid && bus.busy;
    assign addr_ok     = ({1'b0, bus.coef_addr} < (ADDR_W+1)'(DEPTH));

    assign rd_addr  = ADDR_W'(filter) * ADDR_W'(WINDOW_SIZE) + ADDR_W'(tap);
    assign prod     = $signed(snap[tap]) * $signed(coef[rd_addr]);
    assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef TCONV_ROUND_EN
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (FRAC_SHIFT - 1);
    assign rnd = $signed({acc_next[ACC_W-1], acc_next}) + RND_HALF;
`else
    assign rnd = $signed({acc_next[ACC_W-1], acc_next});
`endif
    assign shifted = rnd >>> FRAC_SHIFT;

    always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            snap           <= '0;
            coef           <= '{default: '0};
            tap            <= '0;
            filter         <= '0;
            acc            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_filter <= '0;
            bus.coef_err   <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            bus.coef_err <= 1'b0;
            if (bus.coef_we) begin
                if (state == IDLE && !accept && addr_ok) coef[bus.coef_addr] <= bus.coef_data;
                else                                     bus.coef_err        <= 1'b1;
            end

            if (drop) begin
                bus.overrun <= 1'b1;
                if (bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        snap   <= bus.window;
                        acc    <= '0;
                        tap    <= '0;
                        filter <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + 1'b1;
                    // Result is scaled from acc_next so out_data lands with out_valid.
                    if (tap == TAP_W'(WINDOW_SIZE - 1)) begin
                        state          <= OUT;
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= sat_val;
                        bus.out_filter <= filter;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        tap           <= '0;
                        acc           <= '0;
                        if (!last_filter) begin
                            filter <= filter + 1'b1;
                            state  <= MAC;
                        end else if (accept) begin
                            snap   <= bus.window;
                            filter <= '0;
                            state  <= MAC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_temporal_conv_mac.sv
// Bench for temporal_conv_mac: vector table plus hand-written multi-cycle sequences, results via scoreboard queue.
module tb_temporal_conv_mac;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int WS     = 32;
    localparam int NF     = 4;
    localparam int OUT_W  = 16;
    localparam int AW     = $clog2(NF * WS);

`ifdef TCONV_ROUND_EN
    localparam int R_POS = 2, R_NEG = -1, R_SMALL = 0;
`else
    localparam int R_POS = 1, R_NEG = -2, R_SMALL = -1;
`endif

    typedef struct { int filt; int data; } exp_t;
    typedef struct { int cf; int mode; int cv; int w0; int wm; int wl; int ex [NF]; } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    temporal_conv_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .WINDOW_SIZE(WS),
                           .NUM_FILTERS(NF), .OUT_W(OUT_W)) bus ();

    temporal_conv_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .WINDOW_SIZE(WS), .NUM_FILTERS(NF),
                        .ACC_W(40), .FRAC_SHIFT(14), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) check("unexpected_result", 1, 0);
            else begin
                mon_e = sb_q.pop_front();
                check("out_filter", int'(bus.out_filter), mon_e.filt);
                check("out_data", int'($signed(bus.out_data)), mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.window_valid = 1'b0;
        bus.coef_we = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = COEF_W'(val);
        tick();
        bus.coef_we = 1'b0;
    endtask

    task automatic set_window(input int w0, input int wm, input int wl);
        for (int i = 0; i < WS; i++)
            bus.window[i] = DATA_W'((i == 0) ? w0 : (i == WS-1) ? wl : wm);
    endtask

    task automatic push(input int f, input int d);
        exp_t e;
        e.filt = f;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Strobe now, then check busy in cycle 1 and first out_valid exactly in cycle WS+1.
    task automatic strobe_timed(input string tag);
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        for (int c = 1; c <= WS+1; c++) begin
            @(negedge clk);
            if (c == 1)    check({tag, "_busy_c1"}, int'(bus.busy), 1);
            if (c == WS)   check({tag, "_valid_early"}, int'(bus.out_valid), 0);
            if (c == WS+1) check({tag, "_valid_first"}, int'(bus.out_valid), 1);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic wait_valid(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_data"}, int'(bus.out_data), 0);
        check({tag, "_out_filter"}, int'(bus.out_filter), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_coef_err"}, int'(bus.coef_err), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
        check({tag, "_drop_count"}, int'(bus.drop_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt [8];
        int   hi;
        vt[0] = '{0, 0, 16384,   100,   100,   100, '{100, 0, 0, 0}};
        vt[1] = '{1, 1, 16384,  1000,  1000,  1000, '{0, 32000, 0, 0}};
        vt[2] = '{1, 1, 16384,  2000,  2000,  2000, '{0, 32767, 0, 0}};
        vt[3] = '{1, 1, 16384, -2000, -2000, -2000, '{0, -32768, 0, 0}};
        vt[4] = '{0, 0,  8192,     3,     0,     0, '{R_POS, 0, 0, 0}};
        vt[5] = '{0, 0,  8192,    -3,     0,     0, '{R_NEG, 0, 0, 0}};
        vt[6] = '{3, 2, -16384,    0,     0,   500, '{0, 0, 0, -500}};
        vt[7] = '{2, 1,    -5,     7,     7,     7, '{0, 0, R_SMALL, 0}};

        rst = 1'b1;
        bus.window_valid = 1'b0;
        bus.window = '0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            do_reset();
            case (vt[v].mode)
                0:       wcoef(vt[v].cf * WS, vt[v].cv);
                1:       for (int t = 0; t < WS; t++) wcoef(vt[v].cf * WS + t, vt[v].cv);
                default: wcoef(vt[v].cf * WS + WS - 1, vt[v].cv);
            endcase
            set_window(vt[v].w0, vt[v].wm, vt[v].wl);
            for (int f = 0; f < NF; f++) push(f, vt[v].ex[f]);
            strobe_timed($sformatf("vec%0d", v));
            wait_drain(300);
        end

        // Backpressure: consumer stalls each result, filter 2 held for 10 cycles.
        do_reset();
        for (int f = 0; f < NF; f++) wcoef(f * WS, 4096 * (f + 1));
        set_window(400, 0, 0);
        bus.out_ready = 1'b0;
        for (int f = 0; f < NF; f++) push(f, 100 * (f + 1));
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        for (int f = 0; f < NF; f++) begin
            wait_valid(100);
            if (f == 2) begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("bp_hold_valid", int'(bus.out_valid), 1);
                    check("bp_hold_filter", int'(bus.out_filter), 2);
                    check("bp_hold_data", int'($signed(bus.out_data)), 300);
                end
            end
            if (f == 3) check("bp_busy_stalled", int'(bus.busy), 1);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (f == 3) check("bp_busy_early_accept", int'(bus.busy), 0);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            if (f == 2) begin
                for (int c = 1; c <= WS+1; c++) begin
                    @(negedge clk);
                    if (c == WS)   check("bp_f3_early", int'(bus.out_valid), 0);
                    if (c == WS+1) check("bp_f3_arrive", int'(bus.out_valid), 1);
                end
            end
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_all_consumed", sb_q.size(), 0);

        // Overrun: strobe dropped at cycle 5, then a strobe in the final handshake cycle is accepted.
        do_reset();
        for (int f = 0; f < NF; f++) wcoef(f * WS, 4096 * (f + 1));
        set_window(400, 0, 0);
        for (int f = 0; f < NF; f++) push(f, 100 * (f + 1));
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        set_window(800, 0, 0);
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        @(negedge clk);
        check("ovr_overrun", int'(bus.overrun), 1);
        check("ovr_drop_count", int'(bus.drop_count), 1);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_filter == 2'd3) begin
                hi = 1;
                break;
            end
        end
        check("ovr_last_seen", hi, 1);
        check("ovr_final_busy", int'(bus.busy), 0);
        bus.window_valid = 1'b1;
        for (int f = 0; f < NF; f++) push(f, 200 * (f + 1));
        @(posedge clk);
        #1;
        bus.window_valid = 1'b0;
        @(negedge clk);
        check("ovr_accept_drop_count", int'(bus.drop_count), 1);
        check("ovr_sticky", int'(bus.overrun), 1);
        check("ovr_accept_busy", int'(bus.busy), 1);
        wait_drain(400);

        // Coefficient write rejection during MAC and in a strobe cycle.
        do_reset();
        wcoef(0, 16384);
        @(negedge clk);
        check("wr_ok_no_err", int'(bus.coef_err), 0);
        set_window(100, 100, 100);
        push(0, 100); push(1, 0); push(2, 0); push(3, 0);
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        tick();
        tick();
        wcoef(WS, 16384);
        @(negedge clk);
        check("wr_mac_err", int'(bus.coef_err), 1);
        @(negedge clk);
        check("wr_err_pulse_end", int'(bus.coef_err), 0);
        wait_drain(300);
        bus.coef_we = 1'b1;
        bus.coef_addr = AW'(2 * WS);
        bus.coef_data = 16'd16384;
        bus.window_valid = 1'b1;
        push(0, 100); push(1, 0); push(2, 0); push(3, 0);
        tick();
        bus.coef_we = 1'b0;
        bus.window_valid = 1'b0;
        @(negedge clk);
        check("wr_strobe_err", int'(bus.coef_err), 1);
        wait_drain(300);

        // Reset mid-MAC after a drop: outputs return to reset values, no result, coefficients cleared.
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        check("rst_pre_overrun", int'(bus.overrun), 1);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.out_valid) hi++;
        end
        check("rst_no_partial", hi, 0);
        tick();
        set_window(100, 100, 100);
        for (int f = 0; f < NF; f++) push(f, 0);
        strobe_timed("rst_coef_clear");
        wait_drain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/temporal_conv_mac.md
# temporal_conv_mac

Sequential multiply-accumulate engine that sits directly downstream of the sliding-window generator in the EEG front end. On each `window_valid` it snapshots the full window and computes one signed dot product per temporal filter against a locally stored coefficient bank. It emits one scaled, saturated result per filter over a valid/ready stream to the next ATCNet stage. The block uses one multiplier, time-shared across all taps and filters.

## Interface
- `DATA_W`, 16: signed window sample width.
- `COEF_W`, 16: signed coefficient width, Q(COEF_W-FRAC_SHIFT).FRAC_SHIFT.
- `WINDOW_SIZE`, 32: taps per filter; must match the upstream window length.
- `NUM_FILTERS`, 4: number of filters in the coefficient bank.
- `ACC_W`, 40: accumulator width; must be ≥ DATA_W+COEF_W+clog2(WINDOW_SIZE).
- `FRAC_SHIFT`, 14: right shift applied to the accumulator before output.
- `OUT_W`, 16: signed output width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `window_valid`  in  1  single-cycle strobe; window contents are valid this cycle only.
- `window`  in  WINDOW_SIZE×DATA_W signed  index 0 = oldest sample.
- `busy`  out  1  high when a strobe arriving this cycle would be dropped.
- `coef_we`  in  1  coefficient write enable.
- `coef_addr`  in  clog2(NUM_FILTERS*WINDOW_SIZE)  address = filter*WINDOW_SIZE + tap.
- `coef_data`  in  COEF_W signed  coefficient value.
- `coef_err`  out  1  one-cycle pulse when a write is rejected.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_filter`  out  clog2(NUM_FILTERS)  filter index of `out_data`.
- `out_data`  out  OUT_W signed  result.
- `overrun`  out  1  sticky; set when a strobe is dropped.
- `drop_count`  out  16  number of dropped strobes; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, MAC, OUT.
- **IDLE:**
  - On `window_valid`, latch all samples into snapshot registers.
  - Clear the accumulator and set filter = 0, tap = 0.
  - Go to MAC.
- **MAC:**
  - Each cycle, acc += sext(snap[tap]) × coef[filter][tap], with full-precision signed product sign-extended to ACC_W.
  - tap increments each cycle. After tap = WINDOW_SIZE-1, go to OUT.
- **OUT:**
  - `out_valid` = 1.
  - `out_data` = sat_OUT_W(shift(acc)), where shift is an arithmetic right shift by FRAC_SHIFT (rounding per Configuration).
  - Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - On `out_valid && out_ready`:
    - If filter < NUM_FILTERS-1: filter++, tap = 0, acc = 0, go to MAC.
    - Otherwise: go to IDLE.
- **Early accept:** `busy` = !(state==IDLE || (state==OUT && filter==NUM_FILTERS-1 && out_ready)). This is combinational on `out_ready`. A strobe arriving in the final-handshake cycle is accepted and goes directly to MAC with a new snapshot.
- **Dropped strobe:** a `window_valid` arriving while `busy`=1 is dropped. Snapshot and results are unaffected; `overrun` is set and `drop_count` increments.
- **Coefficient writes:**
  - Accepted only when state==IDLE and no strobe is being accepted in the same cycle.
  - Otherwise the write is ignored and `coef_err` pulses.
- **Reset values:** state IDLE, all coefficients and snapshot registers 0, acc 0, `out_valid` 0, `out_data` 0, `out_filter` 0, `busy` 0, `coef_err` 0, `overrun` 0, `drop_count` 0.
- **Reset mid-operation:** the in-flight computation is abandoned and no partial result is emitted. Coefficients are cleared to 0.

## Timing
- Strobe at cycle 0 → MAC during cycles 1..WINDOW_SIZE → `out_valid` first high in cycle WINDOW_SIZE+1 (cycle 33 at defaults).
- Each subsequent filter takes WINDOW_SIZE+1 cycles with `out_ready` held high.
- Minimum strobe spacing without drops: NUM_FILTERS×(WINDOW_SIZE+1) cycles (132 at defaults).
- `out_data` and `out_filter` are stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a handshake, except on reset.
- A coefficient write takes effect on the next clock edge.

## Configuration
- `TCONV_ROUND_EN` defined: round half up by adding 2^(FRAC_SHIFT-1) to acc before the arithmetic shift.
- `TCONV_ROUND_EN` undefined: plain arithmetic shift (floor toward −∞).

## Test plan
- **Tap selection:** coef[0][0]=16384, all others 0; window = all 100 → filter 0 output 100, filters 1–3 output 0. `out_valid` first at cycle 33.
- **Sum and saturation:**
  - Filter 1 coefficients all 16384, window all 1000 → 32000.
  - Window all 2000 → 32767.
  - Window all −2000 → −32768.
- **Rounding:** coef[0][0]=8192, window[0]=3 → 2 with `TCONV_ROUND_EN`, 1 without. window[0]=−3 → −1 with, −2 without.
- **Backpressure:** hold `out_ready` low for 10 cycles at filter 2 → `out_valid`, `out_data`, and `out_filter`=2 are held. Release → filter 3 result arrives 33 cycles later.
- **Overrun:** second strobe at cycle 5 → dropped, `overrun`=1, `drop_count`=1, all four results unchanged. A strobe in the final-handshake cycle is accepted with `drop_count` still 1.
- **Write rejection:** `coef_we` during MAC → `coef_err` pulse and coefficient unchanged. Assert `rst` mid-MAC → all outputs return to reset values the next cycle.
